// File: rtl/reg_addr_encoder.sv
// reg_addr_encoder: walks a register-select mask and emits one register-file
// address per accepted beat, in ascending (ORDER=0) or descending (ORDER=1)
// index order. The inverse of the register-file address decoder.
module reg_addr_encoder #(
  parameter int N_REGS = 16,
  parameter int ADDR_W = 4,
  parameter int ORDER  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_REGS-1:0] req_vec,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic [ADDR_W:0]   remaining,
  output logic              empty_err,
  output logic              busy
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [N_REGS-1:0] mask, mask_nxt, mask_clr, one_hot;
  logic [ADDR_W-1:0] addr_nxt;
  logic              addr_valid_nxt, addr_last_nxt, empty_err_nxt, busy_nxt;
  logic [ADDR_W:0]   remaining_nxt, req_cnt;

  // Priority encoder over a pending mask; the scan direction is fixed by ORDER.
  function automatic logic [ADDR_W-1:0] pick(input logic [N_REGS-1:0] m);
    logic [ADDR_W-1:0] r;
    r = '0;
    if (ORDER == 0) begin
      for (int i = N_REGS - 1; i >= 0; i--)
        if (m[i]) r = i[ADDR_W-1:0];
    end else begin
      for (int i = 0; i < N_REGS; i++)
        if (m[i]) r = i[ADDR_W-1:0];
    end
    return r;
  endfunction

  // Population count; result range 0..N_REGS so it carries one extra bit.
  function automatic logic [ADDR_W:0] popcnt(input logic [N_REGS-1:0] m);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < N_REGS; i++)
      c = c + {{ADDR_W{1'b0}}, m[i]};
    return c;
  endfunction

  // Upstream may only hand over a new vector while idle.
  assign req_ready = (state == IDLE);

  assign one_hot  = {{(N_REGS-1){1'b0}}, 1'b1} << addr;
  assign mask_clr = mask & ~one_hot;
  assign req_cnt  = popcnt(req_vec);

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt      = state;
    mask_nxt       = mask;
    addr_nxt       = addr;
    addr_valid_nxt = addr_valid;
    addr_last_nxt  = addr_last;
    remaining_nxt  = remaining;
    busy_nxt       = busy;
    empty_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_vec == '0) begin
            empty_err_nxt = 1'b1;
          end else begin
            mask_nxt       = req_vec;
            addr_nxt       = pick(req_vec);
            addr_valid_nxt = 1'b1;
            remaining_nxt  = req_cnt;
            addr_last_nxt  = (req_cnt == {{ADDR_W{1'b0}}, 1'b1});
            busy_nxt       = 1'b1;
            state_nxt      = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (addr_valid && addr_ready) begin
          if (addr_last) begin
            mask_nxt       = '0;
            addr_valid_nxt = 1'b0;
            addr_last_nxt  = 1'b0;
            remaining_nxt  = '0;
            busy_nxt       = 1'b0;
            state_nxt      = IDLE;
          end else begin
            // Retire the delivered bit and present the next one immediately.
            mask_nxt      = mask_clr;
            addr_nxt      = pick(mask_clr);
            remaining_nxt = remaining - 1'b1;
            addr_last_nxt = (remaining == {{(ADDR_W-1){1'b0}}, 2'd2});
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset drops any undelivered addresses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask       <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      addr_last  <= 1'b0;
      remaining  <= '0;
      empty_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      mask       <= mask_nxt;
      addr       <= addr_nxt;
      addr_valid <= addr_valid_nxt;
      addr_last  <= addr_last_nxt;
      remaining  <= remaining_nxt;
      empty_err  <= empty_err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_addr_encoder.sv
// Directed bench for reg_addr_encoder: one ascending and one descending instance.
module tb_reg_addr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  // ORDER=0 instance
  logic        req_valid, req_ready, addr_valid, addr_ready, addr_last, empty_err, busy;
  logic [15:0] req_vec;
  logic [3:0]  addr;
  logic [4:0]  remaining;
  // ORDER=1 instance
  logic        req_valid1, req_ready1, addr_valid1, addr_ready1, addr_last1, empty_err1, busy1;
  logic [15:0] req_vec1;
  logic [3:0]  addr1;
  logic [4:0]  remaining1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_addr_encoder #(.N_REGS(16), .ADDR_W(4), .ORDER(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vec(req_vec), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .addr_last(addr_last), .remaining(remaining),
    .empty_err(empty_err), .busy(busy)
  );

  reg_addr_encoder #(.N_REGS(16), .ADDR_W(4), .ORDER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_vec(req_vec1), .addr_valid(addr_valid1), .addr_ready(addr_ready1),
    .addr(addr1), .addr_last(addr_last1), .remaining(remaining1),
    .empty_err(empty_err1), .busy(busy1)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Put u0 mid-stream with a stalled consumer, then reset for 2 cycles.
    req_valid = 1'b1; req_vec = 16'hFFFF; addr_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    addr_ready = 1'b1;
    total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL rst_addr_valid got=%b want=0", addr_valid); end
    total++; if (addr !== 4'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", addr); end
    total++; if (remaining !== 5'd0) begin bad++; $display("FAIL rst_remaining got=%0d want=0", remaining); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    total++; if (addr_last !== 1'b0 || empty_err !== 1'b0) begin bad++; $display("FAIL rst_last_err got=%b%b want=00", addr_last, empty_err); end
    total++; if (addr_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin bad++; $display("FAIL rst_u1 got=%b%b want=01", addr_valid1, req_ready1); end
    tick();
    total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_beat got=%b want=0", addr_valid); end
  endtask

  task automatic test_stream();
    logic [3:0] exp_a [4];
    exp_a[0] = 4'd0; exp_a[1] = 4'd5; exp_a[2] = 4'd10; exp_a[3] = 4'd15;
    req_valid = 1'b1; req_vec = 16'h8421; addr_ready = 1'b1;
    tick();
    req_valid = 1'b0; req_vec = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      total++; if (addr_valid !== 1'b1) begin bad++; $display("FAIL stream_valid beat=%0d got=%b want=1", i, addr_valid); end
      total++; if (addr !== exp_a[i]) begin bad++; $display("FAIL stream_addr beat=%0d got=%0d want=%0d", i, addr, exp_a[i]); end
      total++; if (remaining !== 5'(4 - i)) begin bad++; $display("FAIL stream_remaining beat=%0d got=%0d want=%0d", i, remaining, 4 - i); end
      total++; if (addr_last !== (i == 3)) begin bad++; $display("FAIL stream_last beat=%0d got=%b want=%b", i, addr_last, (i == 3)); end
      total++; if (req_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stream_ready_busy beat=%0d got=%b%b want=01", i, req_ready, busy); end
      tick();
    end
    total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b want=0", addr_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stream_end_ready got=%b want=1", req_ready); end
    total++; if (remaining !== 5'd0 || busy !== 1'b0) begin bad++; $display("FAIL stream_end_rem_busy got=%0d/%b want=0/0", remaining, busy); end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_vec = 16'h0006; addr_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_vec = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      total++; if (addr_valid !== 1'b1 || addr !== 4'd1) begin bad++; $display("FAIL bp_hold_addr cyc=%0d got=%b/%0d want=1/1", i, addr_valid, addr); end
      total++; if (addr_last !== 1'b0 || remaining !== 5'd2) begin bad++; $display("FAIL bp_hold_state cyc=%0d got=%b/%0d want=0/2", i, addr_last, remaining); end
      if (i < 2) tick();
    end
    addr_ready = 1'b1;
    tick();
    total++; if (addr_valid !== 1'b1 || addr !== 4'd2) begin bad++; $display("FAIL bp_second_addr got=%b/%0d want=1/2", addr_valid, addr); end
    total++; if (addr_last !== 1'b1 || remaining !== 5'd1) begin bad++; $display("FAIL bp_second_last got=%b/%0d want=1/1", addr_last, remaining); end
    tick();
    total++; if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_done got=%b%b want=01", addr_valid, req_ready); end
  endtask

  task automatic test_zero_vector();
    req_valid = 1'b1; req_vec = 16'h0000; addr_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (empty_err !== 1'b1) begin bad++; $display("FAIL zero_err_pulse got=%b want=1", empty_err); end
    total++; if (addr_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%b%b%b want=010", addr_valid, req_ready, busy); end
    tick();
    total++; if (empty_err !== 1'b0) begin bad++; $display("FAIL zero_err_one_cycle got=%b want=0", empty_err); end
    total++; if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL zero_still_idle got=%b%b want=01", addr_valid, req_ready); end
  endtask

  task automatic test_order_desc();
    req_valid1 = 1'b1; req_vec1 = 16'hFFFF; addr_ready1 = 1'b1;
    tick();
    req_valid1 = 1'b0; req_vec1 = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      total++; if (addr_valid1 !== 1'b1 || addr1 !== 4'(15 - i)) begin bad++; $display("FAIL desc_addr beat=%0d got=%b/%0d want=1/%0d", i, addr_valid1, addr1, 15 - i); end
      total++; if (remaining1 !== 5'(16 - i)) begin bad++; $display("FAIL desc_remaining beat=%0d got=%0d want=%0d", i, remaining1, 16 - i); end
      total++; if (addr_last1 !== (i == 15)) begin bad++; $display("FAIL desc_last beat=%0d got=%b want=%b", i, addr_last1, (i == 15)); end
      tick();
    end
    total++; if (addr_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin bad++; $display("FAIL desc_done got=%b%b want=01", addr_valid1, req_ready1); end
  endtask

  task automatic test_reset_mid_drain();
    req_valid = 1'b1; req_vec = 16'h00F0; addr_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (addr !== 4'd4 || addr_valid !== 1'b1) begin bad++; $display("FAIL mid_first got=%b/%0d want=1/4", addr_valid, addr); end
    tick();
    // addr=4 was taken on that edge; drop the rest via reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL mid_no_beats cyc=%0d got=%b/%0d want=0", i, addr_valid, addr); end
      tick();
    end
    req_valid = 1'b1; req_vec = 16'h0001;
    tick();
    req_valid = 1'b0;
    total++; if (addr_valid !== 1'b1 || addr !== 4'd0) begin bad++; $display("FAIL mid_new_addr got=%b/%0d want=1/0", addr_valid, addr); end
    total++; if (addr_last !== 1'b1 || remaining !== 5'd1) begin bad++; $display("FAIL mid_new_last got=%b/%0d want=1/1", addr_last, remaining); end
    tick();
    total++; if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mid_new_done got=%b%b want=01", addr_valid, req_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_vec = '0; addr_ready = 1'b0;
    req_valid1 = 1'b0; req_vec1 = '0; addr_ready1 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_vector();
    test_order_desc();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_addr_encoder.md
Name: reg_addr_encoder

Overview:
- Converts a 16-bit register-select vector into a sequence of 4-bit register-file addresses, one per accepted beat.
- It is the inverse of the register-file address decoder.
- Used by writeback and context-save logic to walk a multi-register mask, for example a store-multiple or a flush of dirty registers, through the single 4-bit register-file port.
- Valid/ready handshake on both sides.

Parameters:
- N_REGS, 16, width of the select vector (number of registers).
- ADDR_W, 4, address width; must equal log2(N_REGS).
- ORDER, 0, scan order: 0 = lowest index first, 1 = highest index first.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  select vector offered.
- req_ready  output  1  encoder can accept a new vector.
- req_vec  input  N_REGS  register-select mask; bit i selects register i.
- addr_valid  output  1  addr holds a valid register address.
- addr_ready  input  1  consumer takes addr this cycle.
- addr  output  ADDR_W  encoded register address.
- addr_last  output  1  current addr is the final one of this vector.
- remaining  output  ADDR_W+1  addresses still to deliver, including the one currently presented.
- empty_err  output  1  one-cycle pulse when an all-zero vector is accepted.
- busy  output  1  high while in DRAIN.

Behaviour:
- Reset (rst_n low at a rising edge), regardless of state:
  - Goes to IDLE and clears the pending mask.
  - addr_valid=0, addr=0, addr_last=0, remaining=0, empty_err=0, busy=0.
  - req_ready=1 from the first cycle after reset.
- A reset during DRAIN discards all undelivered addresses. No further beats are issued.
- All outputs are registered except req_ready, which is decoded from state (req_ready = IDLE).
- State IDLE:
  - req_ready=1, addr_valid=0.
  - If req_valid=1 and req_vec=0: empty_err=1 next cycle for exactly one cycle; stay in IDLE.
  - If req_valid=1 and req_vec≠0: latch the mask and go to DRAIN.
  - On that same edge, load addr with the first selected index (lowest if ORDER=0, highest if ORDER=1), set addr_valid=1, set remaining=popcount(req_vec), and set addr_last=(popcount=1).
  - Latency from request acceptance to first addr_valid is 1 cycle.
- State DRAIN:
  - req_ready=0 and busy=1.
  - If addr_valid=1 and addr_ready=0: addr, addr_last and remaining hold stable.
  - If addr_valid=1 and addr_ready=1 with addr_last=0: clear the delivered bit from the mask. On the same edge, load the next index in scan order and decrement remaining. Throughput is 1 address per cycle under continuous addr_ready.
  - If addr_valid=1 and addr_ready=1 with addr_last=1: clear the mask, addr_valid=0, remaining=0, go to IDLE. req_ready=1 in the following cycle, so there is one bubble cycle between vectors.
- req_vec is sampled only on the acceptance edge. Changes afterwards are ignored.
- Each selected bit produces exactly one beat; no duplicates and no skipped bits. Unselected indices never appear on addr.
- Width rules:
  - remaining holds 0..N_REGS, so it needs ADDR_W+1 bits; 16 must be representable.
  - Index search is a combinational priority encoder over the pending mask, in the direction set by ORDER.
- Boundary cases:
  - Single-bit vector: addr_last=1 on the first beat.
  - Vector 16'hFFFF: 16 beats, remaining counts 16 down to 1.
  - Index 15 and index 0 are both reachable in either order.
- Simultaneous events: req_valid in DRAIN is ignored (req_ready=0); the upstream source must hold the vector. addr_ready while addr_valid=0 has no effect.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles in mid-stream -> addr_valid=0, addr=0, remaining=0, busy=0, req_ready=1 the cycle after release; no stale beats.
- ORDER=0, req_vec=16'h8421, addr_ready held at 1 -> addr=0,5,10,15 on 4 consecutive cycles starting 1 cycle after acceptance; remaining=4,3,2,1; addr_last only with addr=15; req_ready=1 again on the cycle after addr=15 is taken.
- Backpressure: req_vec=16'h0006, addr_ready=0 for 3 cycles, then 1 -> addr=1, addr_last=0 and remaining=2 stay stable for 3 cycles, then addr=1 then addr=2 with addr_last=1.
- Zero vector: req_vec=16'h0000 accepted -> empty_err high for exactly 1 cycle, addr_valid stays 0, state stays IDLE.
- ORDER=1, req_vec=16'hFFFF -> 16 beats with addr=15 down to 0; remaining starts at 16; addr_last only on addr=0.
- Reset mid-drain: req_vec=16'h00F0, reset asserted after addr=4 is taken -> no further beats; a new vector 16'h0001 afterwards yields a single beat addr=0 with addr_last=1.
